// File: rtl/bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_bin
// Purpose  : Sequential packed-BCD to unsigned binary converter using one
//            multiply-by-ten-and-add step per clock.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_bin #(
    parameter int NDIG  = 4,
    parameter int OUT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NDIG-1:0] bcd_in,
    output logic [OUT_W-1:0]  bin_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int ACC_W = OUT_W + 4;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load;
    logic [4*NDIG-1:0]  r_digits;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_bad;
    logic               w_bad_nxt;
    logic [3:0]         w_digit;
    logic               w_last;
    logic [OUT_W-1:0]   r_bin_out;
    logic               r_err;

    // Digit under conversion; r_idx counts down from the most-significant digit.
    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_digit = r_digits[4*i +: 4];
            end
        end
    end

    assign w_acc_nxt = (r_acc << 3) + (r_acc << 1) + {{(ACC_W-4){1'b0}}, w_digit};
    assign w_bad_nxt = r_bad | (w_digit > 4'd9);
    assign w_last    = (r_idx == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_CONV;
                end
            end
            S_CONV: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_CONV;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digits  <= '0;
            r_acc     <= '0;
            r_idx     <= '0;
            r_bad     <= 1'b0;
            r_bin_out <= '0;
            r_err     <= 1'b0;
        end else if (w_load) begin
            r_digits <= bcd_in;
            r_acc    <= '0;
            r_idx    <= C_IDX_LAST;
            r_bad    <= 1'b0;
        end else if (r_state == S_CONV) begin
            r_acc <= w_acc_nxt;
            r_bad <= w_bad_nxt;
            r_idx <= r_idx - IDX_W'(1);
            // Result is published on the same edge that folds in the last digit.
            if (w_last) begin
                r_bin_out <= w_bad_nxt ? '0 : w_acc_nxt[OUT_W-1:0];
                r_err     <= w_bad_nxt;
            end
        end
    end

    assign bin_out = r_bin_out;
    assign err     = r_err;
    assign busy    = (r_state == S_CONV);
    assign done    = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_to_bin
// Purpose  : Scoreboard bench for bcd_to_bin (default and 2-digit variants).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start1 = 1'b0;
    logic [15:0] bcd1 = 16'h0;
    logic [15:0] bin1;
    logic        busy1, done1, err1;
    logic        start2 = 1'b0;
    logic [7:0]  bcd2 = 8'h0;
    logic [6:0]  bin2;
    logic        busy2, done2, err2;

    int n_assert  = 0;
    int n_fail    = 0;
    int done_cnt1 = 0;
    int done_cnt2 = 0;
    logic [16:0] q1[$];
    logic [16:0] q2[$];
    logic [16:0] e1, e2;

    always #5 clk = ~clk;

    bcd_to_bin #(.NDIG(4), .OUT_W(16)) dut4 (
        .clk(clk), .rst(rst), .start(start1), .bcd_in(bcd1),
        .bin_out(bin1), .busy(busy1), .done(done1), .err(err1)
    );

    bcd_to_bin #(.NDIG(2), .OUT_W(7)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .bcd_in(bcd2),
        .bin_out(bin2), .busy(busy2), .done(done2), .err(err2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Scoreboard: every done pulse pops and checks one expected result.
    always @(negedge clk) begin
        if (!rst && done1 === 1'b1) begin
            done_cnt1++;
            if (q1.size() == 0) begin
                check("dut4_spurious_done", 32'(q1.size()), 32'd1);
            end else begin
                e1 = q1.pop_front();
                check("dut4_bin", 32'(bin1), 32'(e1[15:0]));
                check("dut4_err", 32'(err1), 32'(e1[16]));
            end
        end
        if (!rst && done2 === 1'b1) begin
            done_cnt2++;
            if (q2.size() == 0) begin
                check("dut2_spurious_done", 32'(q2.size()), 32'd1);
            end else begin
                e2 = q2.pop_front();
                check("dut2_bin", 32'(bin2), 32'(e2[15:0]));
                check("dut2_err", 32'(err2), 32'(e2[16]));
            end
        end
    end

    task automatic conv1(input logic [15:0] bcd, input logic [15:0] want_bin,
                         input logic want_err, input string tag);
        int cyc;
        int c0;
        c0 = done_cnt1;
        q1.push_back({want_err, want_bin});
        start1 = 1'b1;
        bcd1   = bcd;
        cyc    = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start1 = 1'b0;
            if (done1 !== 1'b1) check({tag, "_busy"}, 32'(busy1), 32'd1);
        end while (done1 !== 1'b1 && cyc < 20);
        check({tag, "_latency"}, 32'(cyc - 1), 32'd4);
        @(negedge clk);
        check({tag, "_done_drop"}, 32'(done1), 32'd0);
        check({tag, "_done_count"}, 32'(done_cnt1 - c0), 32'd1);
    endtask

    task automatic conv2(input logic [7:0] bcd, input logic [6:0] want_bin, input string tag);
        int cyc;
        int c0;
        c0 = done_cnt2;
        q2.push_back({1'b0, 9'd0, want_bin});
        start2 = 1'b1;
        bcd2   = bcd;
        cyc    = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start2 = 1'b0;
            if (done2 !== 1'b1) check({tag, "_busy"}, 32'(busy2), 32'd1);
        end while (done2 !== 1'b1 && cyc < 20);
        check({tag, "_latency"}, 32'(cyc - 1), 32'd2);
        @(negedge clk);
        check({tag, "_done_count"}, 32'(done_cnt2 - c0), 32'd1);
    endtask

    initial begin
        int t[3];
        int nd;
        int c0;

        #1 rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_bin",  32'(bin1),  32'd0);
        check("rst_err",  32'(err1),  32'd0);
        check("rst_bin2", 32'(bin2),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        conv1(16'h1234, 16'd1234, 1'b0, "c1234");

        // Back-to-back chain with start held: 9999, 0000, 0001.
        nd = 0;
        q1.push_back({1'b0, 16'h270F});
        start1 = 1'b1;
        bcd1   = 16'h9999;
        @(negedge clk);
        bcd1 = 16'h0000;
        q1.push_back({1'b0, 16'h0000});
        for (int n = 2; n <= 20; n++) begin
            @(negedge clk);
            if (done1 === 1'b1) begin
                if (nd < 3) t[nd] = n;
                nd++;
            end
            if (n == 6) begin
                bcd1 = 16'h0001;
                q1.push_back({1'b0, 16'h0001});
            end
            if (n == 11) start1 = 1'b0;
        end
        check("b2b_done_count", 32'(nd), 32'd3);
        check("b2b_first_done", 32'(t[0]), 32'd5);
        check("b2b_gap1", 32'(t[1] - t[0]), 32'd5);
        check("b2b_gap2", 32'(t[2] - t[1]), 32'd5);

        conv1(16'h12A4, 16'd0, 1'b1, "bad_digit");
        conv1(16'h0042, 16'd42, 1'b0, "after_bad");

        // Start pulse and new digits during CONV must be ignored.
        nd = 0;
        q1.push_back({1'b0, 16'd500});
        start1 = 1'b1;
        bcd1   = 16'h0500;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) start1 = 1'b0;
            if (n == 2) begin start1 = 1'b1; bcd1 = 16'h9999; end
            if (n == 3) start1 = 1'b0;
            if (done1 === 1'b1) nd++;
        end
        check("ignore_done_count", 32'(nd), 32'd1);

        conv2(8'h99, 7'd99, "v99");
        conv2(8'h07, 7'd7, "v07");

        // Asynchronous reset during the second CONV cycle.
        c0 = done_cnt1;
        start1 = 1'b1;
        bcd1   = 16'h1111;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy1), 32'd0);
        check("midrst_done", 32'(done1), 32'd0);
        check("midrst_bin",  32'(bin1),  32'd0);
        check("midrst_err",  32'(err1),  32'd0);
        check("midrst_bin2", 32'(bin2),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt1 - c0), 32'd0);

        conv1(16'h0777, 16'd777, 1'b0, "c0777");

        repeat (3) @(negedge clk);
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
